uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-entry holding buffer feeding a bit-rate frame FSM.
// Frames are start, 5..MAX_DATA data bits, optional parity, then one or two stop bits.
module uart_tx_serializer #(
  parameter int unsigned MAX_DATA   = 9,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                BaudOut,
  input  logic                rst,
  input  logic [MAX_DATA-1:0] data_in,
  input  logic [3:0]          data_length,
  input  logic [1:0]          parity_type,
  input  logic                stop_bits,
  input  logic                msb_first,
  input  logic                send,
  output logic                ready,
  output logic                data_out,
  output logic                p_parity_out,
  output logic                tx_active,
  output logic                tx_done
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;

  localparam logic [3:0] MaxLen = 4'(MAX_DATA);

  state_e              r_state;
  logic                r_buf_full;
  logic [MAX_DATA-1:0] r_buf_data;
  logic [3:0]          r_buf_len;
  logic                r_buf_par_en;
  logic                r_buf_par;
  logic                r_buf_stop2;
  logic                r_buf_msb;
  logic [MAX_DATA-1:0] r_shift;
  logic [3:0]          r_len;
  logic [3:0]          r_cnt;
  logic                r_par_en;
  logic                r_par;
  logic                r_stop2;
  logic                r_msb;
  logic                r_data_out;
  logic                r_parity_out;
  logic                r_tx_active;
  logic                r_tx_done;

  logic [3:0]          w_len;
  logic                w_par_x;
  logic                w_par;
  logic                w_frame_end;
  logic                w_cur_bit;
  logic [MAX_DATA-1:0] w_shift_nxt;

  always_comb begin
    w_len = data_length;
    if (data_length < 4'd5) begin
      w_len = 4'd5;
    end else if (data_length > MaxLen) begin
      w_len = MaxLen;
    end
    w_par_x = 1'b0;
    for (int unsigned i = 0; i < MAX_DATA; i++) begin
      if (4'(i) < w_len) w_par_x = w_par_x ^ data_in[i];
    end
    case (parity_type)
      2'b01:   w_par = ~w_par_x;
      2'b10:   w_par = w_par_x;
      default: w_par = 1'b0;
    endcase
  end

  assign w_frame_end = ((r_state == StStop1) && !r_stop2) || (r_state == StStop2);
  // MSB-first reads the top of the effective word, so the index follows the latched length.
  assign w_cur_bit   = r_msb ? r_shift[r_len - 4'd1] : r_shift[0];
  assign w_shift_nxt = r_msb ? {r_shift[MAX_DATA-2:0], 1'b0} : {1'b0, r_shift[MAX_DATA-1:1]};

  always_ff @(posedge BaudOut or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_buf_full   <= 1'b0;
      r_buf_data   <= '0;
      r_buf_len    <= 4'd5;
      r_buf_par_en <= 1'b0;
      r_buf_par    <= 1'b0;
      r_buf_stop2  <= 1'b0;
      r_buf_msb    <= 1'b0;
      r_shift      <= '0;
      r_len        <= 4'd5;
      r_cnt        <= '0;
      r_par_en     <= 1'b0;
      r_par        <= 1'b0;
      r_stop2      <= 1'b0;
      r_msb        <= 1'b0;
      r_data_out   <= IDLE_LEVEL;
      r_parity_out <= 1'b0;
      r_tx_active  <= 1'b0;
      r_tx_done    <= 1'b0;
    end else begin
      r_tx_done <= w_frame_end;

      if (send && !r_buf_full) begin
        r_buf_full   <= 1'b1;
        r_buf_data   <= data_in;
        r_buf_len    <= w_len;
        r_buf_par_en <= ^parity_type;
        r_buf_par    <= w_par;
        r_buf_stop2  <= stop_bits;
        r_buf_msb    <= msb_first;
        r_parity_out <= w_par;
      end

      // The parity bit comes from the frame copy so a word accepted mid-frame cannot alter it.
      if ((r_state == StIdle || w_frame_end) && r_buf_full) begin
        r_state     <= StStart;
        r_buf_full  <= 1'b0;
        r_shift     <= r_buf_data;
        r_len       <= r_buf_len;
        r_par_en    <= r_buf_par_en;
        r_par       <= r_buf_par;
        r_stop2     <= r_buf_stop2;
        r_msb       <= r_buf_msb;
        r_data_out  <= 1'b0;
        r_tx_active <= 1'b1;
      end else if (w_frame_end) begin
        r_state     <= StIdle;
        r_data_out  <= IDLE_LEVEL;
        r_tx_active <= 1'b0;
      end else begin
        case (r_state)
          StStart: begin
            r_state    <= StData;
            r_cnt      <= r_len - 4'd1;
            r_data_out <= w_cur_bit;
            r_shift    <= w_shift_nxt;
          end
          StData: begin
            if (r_cnt != 4'd0) begin
              r_cnt      <= r_cnt - 4'd1;
              r_data_out <= w_cur_bit;
              r_shift    <= w_shift_nxt;
            end else if (r_par_en) begin
              r_state    <= StParity;
              r_data_out <= r_par;
            end else begin
              r_state    <= StStop1;
              r_data_out <= 1'b1;
            end
          end
          StParity: begin
            r_state    <= StStop1;
            r_data_out <= 1'b1;
          end
          StStop1: begin
            r_state    <= StStop2;
            r_data_out <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ready        = ~r_buf_full;
  assign data_out     = r_data_out;
  assign p_parity_out = r_parity_out;
  assign tx_active    = r_tx_active;
  assign tx_done      = r_tx_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer; expected line sequences are hand-computed.
module tb_uart_tx_serializer;

  logic       BaudOut;
  logic       rst;
  logic [8:0] data_in;
  logic [3:0] data_length;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       msb_first;
  logic       send;
  logic       ready;
  logic       data_out;
  logic       p_parity_out;
  logic       tx_active;
  logic       tx_done;

  int n_checks;
  int n_errors;

  uart_tx_serializer #(
    .MAX_DATA  (9),
    .IDLE_LEVEL(1'b1)
  ) u_dut (
    .BaudOut     (BaudOut),
    .rst         (rst),
    .data_in     (data_in),
    .data_length (data_length),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .msb_first   (msb_first),
    .send        (send),
    .ready       (ready),
    .data_out    (data_out),
    .p_parity_out(p_parity_out),
    .tx_active   (tx_active),
    .tx_done     (tx_done)
  );

  initial begin
    BaudOut = 1'b0;
    forever #5 BaudOut = ~BaudOut;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents a word so it is accepted on the next rising edge (edge 0 of the frame).
  task automatic send_word(input logic [8:0] d, input logic [3:0] len, input logic [1:0] par,
                           input logic stop2, input logic msb);
    data_in     = d;
    data_length = len;
    parity_type = par;
    stop_bits   = stop2;
    msb_first   = msb;
    send        = 1'b1;
    @(posedge BaudOut);
    #1;
    send = 1'b0;
    check_eq("ready_after_accept", 32'(ready), 32'd0);
  endtask

  // exp[n-1] is the line level after edge 1, exp[0] after edge n; tx_done follows on edge n+1.
  task automatic expect_frame(input string tag, input int n, input logic [15:0] exp);
    for (int k = 1; k <= n; k++) begin
      @(posedge BaudOut);
      #1;
      check_eq({tag, "_bit"}, 32'(data_out), 32'(exp[n-k]));
      check_eq({tag, "_active"}, 32'(tx_active), 32'd1);
      check_eq({tag, "_nodone"}, 32'(tx_done), 32'd0);
    end
    @(posedge BaudOut);
    #1;
    check_eq({tag, "_done"}, 32'(tx_done), 32'd1);
    check_eq({tag, "_idle_active"}, 32'(tx_active), 32'd0);
    check_eq({tag, "_idle_line"}, 32'(data_out), 32'd1);
    @(posedge BaudOut);
    #1;
    check_eq({tag, "_done_clr"}, 32'(tx_done), 32'd0);
  endtask

  // Two back-to-back frames: 0x0F then 0x33, 8N1 LSB-first.
  // Mode 0 sends the second word mid-frame; mode 1 holds send high across both.
  task automatic run_stream(input int mode);
    logic [19:0] stream;
    int          done_cnt;
    stream   = 20'b0111100001_0110011001;
    done_cnt = 0;
    data_in     = 9'h00F;
    data_length = 4'd8;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    msb_first   = 1'b0;
    send        = 1'b1;
    @(posedge BaudOut);
    #1;
    check_eq("stream_rdy0", 32'(ready), 32'd0);
    if (mode == 0) send = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(posedge BaudOut);
      #1;
      if (k <= 20) begin
        check_eq("stream_bit", 32'(data_out), 32'(stream[20-k]));
        check_eq("stream_active", 32'(tx_active), 32'd1);
      end else begin
        check_eq("stream_end_active", 32'(tx_active), 32'd0);
        check_eq("stream_end_line", 32'(data_out), 32'd1);
      end
      check_eq("stream_done", 32'(tx_done), 32'((k == 11) || (k == 21)));
      if (tx_done) done_cnt++;
      if (k == 1 || k == 11) check_eq("stream_rdy_load", 32'(ready), 32'd1);
      if (mode == 1 && k >= 2 && k <= 10) check_eq("stream_rdy_full", 32'(ready), 32'd0);
      if (mode == 0) begin
        if (k == 2) begin
          data_in = 9'h033;
          send    = 1'b1;
        end
        if (k == 3) send = 1'b0;
      end else begin
        if (k == 1) data_in = 9'h033;
        if (k == 2) data_in = 9'h0FF;
        if (k == 9) send = 1'b0;
      end
    end
    check_eq("stream_done_cnt", 32'(done_cnt), 32'd2);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b0;
    data_in     = '0;
    data_length = '0;
    parity_type = '0;
    stop_bits   = 1'b0;
    msb_first   = 1'b0;
    send        = 1'b0;
    #12;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_line", 32'(data_out), 32'd1);
    check_eq("rst_parity", 32'(p_parity_out), 32'd0);
    check_eq("rst_active", 32'(tx_active), 32'd0);
    check_eq("rst_done", 32'(tx_done), 32'd0);
    rst = 1'b1;

    // 0xA5, 8 bits, even parity, 1 stop, LSB-first
    send_word(9'h0A5, 4'd8, 2'b10, 1'b0, 1'b0);
    check_eq("a5_parity", 32'(p_parity_out), 32'd0);
    expect_frame("a5", 11, 16'b01010010101);

    // 0x41, 7 bits, odd parity, 2 stop, MSB-first; config inputs scrambled mid-frame
    send_word(9'h041, 4'd7, 2'b01, 1'b1, 1'b1);
    check_eq("41_parity", 32'(p_parity_out), 32'd1);
    data_in     = 9'h1FF;
    data_length = 4'd15;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    msb_first   = 1'b0;
    expect_frame("41", 11, 16'b01000001111);
    check_eq("41_parity_hold", 32'(p_parity_out), 32'd1);

    run_stream(0);
    run_stream(1);

    // Reset asserted while the frame is in its data bits
    send_word(9'h0A5, 4'd8, 2'b01, 1'b0, 1'b0);
    check_eq("abort_parity", 32'(p_parity_out), 32'd1);
    repeat (4) @(posedge BaudOut);
    #1;
    rst = 1'b0;
    #1;
    check_eq("abort_line", 32'(data_out), 32'd1);
    check_eq("abort_active", 32'(tx_active), 32'd0);
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_parity_clr", 32'(p_parity_out), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge BaudOut);
      #1;
      check_eq("abort_nodone", 32'(tx_done), 32'd0);
      check_eq("abort_hold_line", 32'(data_out), 32'd1);
    end
    rst = 1'b1;
    send_word(9'h055, 4'd8, 2'b00, 1'b0, 1'b0);
    expect_frame("55", 10, 16'b0101010101);

    // Length clamps: 3 -> 5 bits (even parity over those 5), 15 -> 9 bits
    send_word(9'h0E2, 4'd3, 2'b10, 1'b0, 1'b0);
    check_eq("len3_parity", 32'(p_parity_out), 32'd1);
    expect_frame("len3", 8, 16'b00100011);
    send_word(9'h1A5, 4'd15, 2'b11, 1'b0, 1'b0);
    check_eq("len15_parity", 32'(p_parity_out), 32'd0);
    expect_frame("len15", 11, 16'b01010010111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
